ahb_single_master: RTL and testbench

AHB-Lite initiator issuing single, byte-wide read and write transfers on behalf of a local command source. It converts a valid/ready command interface into AHB address and data phases, overlaps the next address phase with the current data phase, and returns one registered response per transfer. It sits opposite the peripheral-side AHB read/write responders and drives the bus they decode.

---
 rtl/ahb_pkg.sv | 17 +
 rtl/ahb_single_master.sv | 105 ++++++++++
 tb/tb_ahb_single_master.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the initiator and the peripheral-side responders.
// Only the transfer types and the fixed size/burst/response codes live here.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

endpackage

// File: rtl/ahb_single_master.sv
// AHB-Lite initiator for single byte transfers: the address phase comes straight from the
// command port, the data phase is tracked by a small register set, and each transfer gets one response.
module ahb_single_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WAIT_W = 4
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [WAIT_W-1:0] rsp_wait,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  input  logic [DATA_W-1:0] hrdata
);

  logic              r_dp_active;
  logic              r_dp_write;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [DATA_W-1:0] r_hwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [WAIT_W-1:0] r_rsp_wait;

  logic w_err1;
  logic w_issue;
  logic w_accept;
  logic w_complete;

  // First cycle of a two-cycle ERROR: the next address phase must be withdrawn.
  assign w_err1     = r_dp_active && (hresp == HRESP_ERROR) && !hready;
  assign w_issue    = cmd_valid && !w_err1 && !hreset;
  assign w_accept   = w_issue && hready;
  assign w_complete = r_dp_active && hready;

  assign cmd_ready = hready && !w_err1 && !hreset;
  assign htrans    = w_issue ? NONSEQ : IDLE;
  assign haddr     = cmd_addr;
  assign hwrite    = cmd_write;
  assign hsize     = HSIZE_BYTE;
  assign hburst    = HBURST_SINGLE;
  assign hwdata    = r_hwdata;

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign rsp_wait  = r_rsp_wait;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_dp_active <= 1'b0;
      r_dp_write  <= 1'b0;
      r_wait_cnt  <= '0;
      r_hwdata    <= '0;
    end else begin
      if (w_accept) begin
        r_dp_active <= 1'b1;
        r_dp_write  <= cmd_write;
        r_wait_cnt  <= '0;
        if (cmd_write) begin
          r_hwdata <= cmd_wdata;
        end
      end else if (hready) begin
        r_dp_active <= 1'b0;
      end
      // Acceptance needs hready, so this never collides with the clear above.
      if (r_dp_active && !hready && (r_wait_cnt != {WAIT_W{1'b1}})) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_wait  <= '0;
    end else begin
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_rdata <= r_dp_write ? '0 : hrdata;
        r_rsp_err   <= hresp;
        r_rsp_wait  <= r_wait_cnt;
      end
    end
  end

endmodule

// File: tb/tb_ahb_single_master.sv
// Directed bench for ahb_single_master: a transfer-level model tracks in-flight transfers and
// expected responses; a compare process checks every cycle, and literal checks pin the model.
module tb_ahb_single_master;

  logic       hclk;
  logic       hreset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [3:0] rsp_wait;
  logic [1:0] htrans;
  logic [7:0] haddr;
  logic       hwrite;
  logic [2:0] hsize;
  logic [2:0] hburst;
  logic [7:0] hwdata;
  logic       hready;
  logic       hresp;
  logic [7:0] hrdata;

  int vectors = 0;
  int miscompares = 0;

  ahb_single_master #(.ADDR_W(8), .DATA_W(8), .WAIT_W(4)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_wait(rsp_wait),
    .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- transfer-level model ----------------
  typedef struct {
    logic       write;
    logic [7:0] addr;
    int         waits;
  } xfer_t;

  xfer_t      inflight[$];
  logic       m_rsp_valid = 1'b0;
  logic [7:0] m_rsp_rdata = 8'h00;
  logic       m_rsp_err   = 1'b0;
  int         m_rsp_wait  = 0;
  logic [7:0] m_hwdata    = 8'h00;

  initial begin
    forever begin
      @(posedge hclk);
      if (hreset) begin
        inflight.delete();
        m_rsp_valid = 1'b0;
        m_rsp_rdata = 8'h00;
        m_rsp_err   = 1'b0;
        m_rsp_wait  = 0;
        m_hwdata    = 8'h00;
      end else begin
        bit    busy;
        bit    err_first;
        bit    accept;
        xfer_t nx;
        busy      = (inflight.size() != 0);
        err_first = busy && hresp && !hready;
        accept    = cmd_valid && hready && !err_first;
        m_rsp_valid = 1'b0;
        if (busy && hready) begin
          xfer_t done;
          done = inflight.pop_front();
          m_rsp_valid = 1'b1;
          m_rsp_rdata = done.write ? 8'h00 : hrdata;
          m_rsp_err   = hresp;
          m_rsp_wait  = (done.waits > 15) ? 15 : done.waits;
          $display("txn %s addr=0x%02h rdata=0x%02h err=%0d waits=%0d",
                   done.write ? "WR" : "RD", done.addr, m_rsp_rdata, m_rsp_err, m_rsp_wait);
        end else if (busy) begin
          inflight[0].waits = inflight[0].waits + 1;
        end
        if (accept) begin
          nx.write = cmd_write;
          nx.addr  = cmd_addr;
          nx.waits = 0;
          inflight.push_back(nx);
          if (cmd_write) m_hwdata = cmd_wdata;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge hclk);
      begin
        bit busy;
        bit err_first;
        busy      = (inflight.size() != 0) && !hreset;
        err_first = busy && hresp && !hready;
        chk("htrans",    {30'd0, htrans}, (!hreset && cmd_valid && !err_first) ? 32'd2 : 32'd0);
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, (!hreset && hready && !err_first)});
        chk("haddr",     {24'd0, haddr}, {24'd0, cmd_addr});
        chk("hwrite",    {31'd0, hwrite}, {31'd0, cmd_write});
        chk("hsize",     {29'd0, hsize}, 32'd0);
        chk("hburst",    {29'd0, hburst}, 32'd0);
        chk("hwdata",    {24'd0, hwdata}, hreset ? 32'd0 : {24'd0, m_hwdata});
        chk("rsp_valid", {31'd0, rsp_valid}, hreset ? 32'd0 : {31'd0, m_rsp_valid});
        chk("rsp_rdata", {24'd0, rsp_rdata}, hreset ? 32'd0 : {24'd0, m_rsp_rdata});
        chk("rsp_err",   {31'd0, rsp_err}, hreset ? 32'd0 : {31'd0, m_rsp_err});
        chk("rsp_wait",  {28'd0, rsp_wait}, hreset ? 32'd0 : m_rsp_wait);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic rst, input logic v, input logic w, input logic [7:0] a,
                     input logic [7:0] d, input logic rdy, input logic rsp, input logic [7:0] rd);
    @(posedge hclk);
    #1;
    hreset    = rst;
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    hready    = rdy;
    hresp     = rsp;
    hrdata    = rd;
    @(negedge hclk);
  endtask

  task automatic idle(input logic rdy);
    drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, rdy, 1'b0, 8'h00);
  endtask

  initial begin
    hreset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'hEE;
    hready = 1'b1; hresp = 1'b0; hrdata = 8'h00;

    // Reset held with a command present
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 1'b1, 1'b1, 8'h55, 8'hEE, 1'b1, 1'b0, 8'h00);
      chk("rst_htrans", {30'd0, htrans}, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
      chk("rst_hwdata", {24'd0, hwdata}, 32'd0);
      chk("rst_rsp", {19'd0, rsp_valid, rsp_rdata, rsp_err, rsp_wait}, 32'd0);
    end
    idle(1'b1);

    // Single zero-wait write
    drv(1'b0, 1'b1, 1'b1, 8'h12, 8'hA5, 1'b1, 1'b0, 8'h00);
    chk("wr_c0_htrans", {30'd0, htrans}, 32'd2);
    chk("wr_c0_haddr", {24'd0, haddr}, 32'h12);
    chk("wr_c0_hwrite", {31'd0, hwrite}, 32'd1);
    idle(1'b1);
    chk("wr_c1_hwdata", {24'd0, hwdata}, 32'hA5);
    chk("wr_c1_htrans", {30'd0, htrans}, 32'd0);
    idle(1'b1);
    chk("wr_c2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("wr_c2_err", {31'd0, rsp_err}, 32'd0);
    chk("wr_c2_wait", {28'd0, rsp_wait}, 32'd0);
    chk("wr_c2_rdata", {24'd0, rsp_rdata}, 32'd0);

    // Read with three wait states
    drv(1'b0, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      chk("rd_wait_ready", {31'd0, cmd_ready}, 32'd0);
    end
    drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h3C);
    idle(1'b1);
    chk("rd_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rd_rdata", {24'd0, rsp_rdata}, 32'h3C);
    chk("rd_wait", {28'd0, rsp_wait}, 32'd3);

    // Back-to-back read then write
    drv(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("b2b_c0_htrans", {30'd0, htrans}, 32'd2);
    drv(1'b0, 1'b1, 1'b1, 8'h03, 8'h5A, 1'b1, 1'b0, 8'h77);
    chk("b2b_c1_htrans", {30'd0, htrans}, 32'd2);
    idle(1'b1);
    chk("b2b_c2_hwdata", {24'd0, hwdata}, 32'h5A);
    chk("b2b_c2_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_c2_rdata", {24'd0, rsp_rdata}, 32'h77);
    idle(1'b1);
    chk("b2b_c3_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_c3_rdata", {24'd0, rsp_rdata}, 32'h00);

    // Another slave stalls the bus while we are idle: no acceptance, no response
    drv(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("foreign_wait_ready", {31'd0, cmd_ready}, 32'd0);
    drv(1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("foreign_wait_valid", {31'd0, rsp_valid}, 32'd0);
    drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h44);
    idle(1'b1);
    chk("foreign_rd_rdata", {24'd0, rsp_rdata}, 32'h44);
    chk("foreign_rd_wait", {28'd0, rsp_wait}, 32'd0);

    // Read gets ERROR while a write is pending
    drv(1'b0, 1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h00);
    drv(1'b0, 1'b1, 1'b1, 8'h41, 8'h99, 1'b0, 1'b1, 8'h00);
    chk("err_c1_htrans", {30'd0, htrans}, 32'd0);
    chk("err_c1_ready", {31'd0, cmd_ready}, 32'd0);
    drv(1'b0, 1'b1, 1'b1, 8'h41, 8'h99, 1'b1, 1'b1, 8'h00);
    chk("err_c2_htrans", {30'd0, htrans}, 32'd2);
    chk("err_c2_ready", {31'd0, cmd_ready}, 32'd1);
    idle(1'b1);
    chk("err_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("err_rsp_wait", {28'd0, rsp_wait}, 32'd1);
    chk("err_hwdata", {24'd0, hwdata}, 32'h99);
    idle(1'b1);
    chk("err_next_err", {31'd0, rsp_err}, 32'd0);
    chk("err_next_valid", {31'd0, rsp_valid}, 32'd1);

    // Twenty wait states saturate the counter
    drv(1'b0, 1'b1, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      idle(1'b0);
      chk("sat_no_valid", {31'd0, rsp_valid}, 32'd0);
    end
    drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11);
    idle(1'b1);
    chk("sat_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sat_wait", {28'd0, rsp_wait}, 32'd15);
    chk("sat_rdata", {24'd0, rsp_rdata}, 32'h11);

    // Reset arrives during a long data phase: transfer dropped
    drv(1'b0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) idle(1'b0);
    drv(1'b1, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("mid_rst_htrans", {30'd0, htrans}, 32'd0);
    chk("mid_rst_rsp", {19'd0, rsp_valid, rsp_rdata, rsp_err, rsp_wait}, 32'd0);
    chk("mid_rst_hwdata", {24'd0, hwdata}, 32'd0);
    drv(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF);
      chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
